// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The host drives the stream (master); the loader accepts bytes and drives the write port (slave).
interface prog_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   // A byte transfers on a rising edge where in_valid and in_ready are both high;
   // in_data must stay stable while in_valid is high and in_ready is low.
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;

   modport master (
      output in_data, in_valid,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/prog_loader.sv
// Loads a framed byte stream (sync, length, payload, XOR checksum) into instruction memory
// and keeps the core in reset until a full image with a matching checksum has arrived.
module prog_loader #(
   parameter int         ADDR_WIDTH = 8,
   parameter int         BASE_ADDR  = 0,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic         clk_i,
   input  logic         reset_ni,
   prog_loader_if.slave bus,
   output logic         cpu_reset_o,
   output logic         done_o,
   output logic         error_o,
   output logic [2:0]   state_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERR
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [16:0]           MAX_WORDS = 17'(1) << ADDR_WIDTH;

   state_e                state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [16:0]           word_idx_q, word_idx_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic [7:0]            chk_q, chk_d;
   logic [31:0]           word_q, word_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  cpu_reset_q, cpu_reset_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  accept;
   logic                  is_sync;
   logic [15:0]           n_words;

   // The write cycle doubles as the one-cycle bubble, so ready is simply the inverse of the strobe.
   assign accept  = bus.in_valid && !we_q;
   assign is_sync = (bus.in_data == SYNC_BYTE);
   assign n_words = {bus.in_data, len_q[7:0]};

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      word_idx_d  = word_idx_q;
      byte_idx_d  = byte_idx_q;
      chk_d       = chk_q;
      word_d      = word_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_reset_d = cpu_reset_q;
      done_d      = done_q;
      error_d     = error_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (accept && is_sync) begin
               state_d     = S_LEN_LO;
               chk_d       = 8'h00;
               word_idx_d  = 17'd0;
               byte_idx_d  = 2'd0;
               word_d      = 32'h0;
               cpu_reset_d = 1'b1;
               done_d      = 1'b0;
               error_d     = 1'b0;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d   = {8'h00, bus.in_data};
               state_d = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d = n_words;
               if ({1'b0, n_words} > MAX_WORDS) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end else if (n_words == 16'd0) begin
                  state_d = S_CHK;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               chk_d                     = chk_q ^ bus.in_data;
               word_d[8*byte_idx_q +: 8] = bus.in_data;
               byte_idx_d                = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  we_d       = 1'b1;
                  addr_d     = BASE + ADDR_WIDTH'(word_idx_q);
                  wdata_d    = {bus.in_data, word_q[23:0]};
                  word_idx_d = word_idx_q + 17'd1;
                  if (word_idx_q + 17'd1 == {1'b0, len_q}) begin
                     state_d = S_CHK;
                  end
               end
            end
         end
         S_CHK: begin
            if (accept) begin
               if (bus.in_data == chk_q) begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  cpu_reset_d = 1'b0;
               end else begin
                  state_d     = S_ERR;
                  error_d     = 1'b1;
                  cpu_reset_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= S_IDLE;
         len_q       <= 16'h0;
         word_idx_q  <= 17'd0;
         byte_idx_q  <= 2'd0;
         chk_q       <= 8'h00;
         word_q      <= 32'h0;
         we_q        <= 1'b0;
         addr_q      <= BASE;
         wdata_q     <= 32'h0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         word_idx_q  <= word_idx_d;
         byte_idx_q  <= byte_idx_d;
         chk_q       <= chk_d;
         word_q      <= word_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign bus.in_ready   = !we_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign cpu_reset_o    = cpu_reset_q;
   assign done_o         = done_q;
   assign error_o        = error_q;
   assign state_o        = state_q;

endmodule
